// File: rtl/mutual_rule_sched_if.sv
// rtl/mutual_rule_sched_if.sv - guard/stall/enable bundle between the system block and its rule scheduler
interface mutual_rule_sched_if #(
  parameter int NUM_RULES = 3
);
  logic [NUM_RULES-1:0] io_guard;
  logic                 io_stall;
  logic [NUM_RULES-1:0] io_en_a;
  logic                 io_fired;

  modport master (
    output io_guard,
    output io_stall,
    input  io_en_a,
    input  io_fired
  );

  modport slave (
    input  io_guard,
    input  io_stall,
    output io_en_a,
    output io_fired
  );
endinterface

// File: rtl/mutual_rule_sched.sv
// rtl/mutual_rule_sched.sv - round-robin single-rule scheduler with saturating fire counter
// Optional starvation monitor and io_starve port built when MUTUAL_SCHED_STARVE_EN is defined.
module mutual_rule_sched #(
  parameter int NUM_RULES    = 3,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16,
  localparam int PTR_W       = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  mutual_rule_sched_if.slave   bus,
  output logic [PTR_W-1:0]     io_ptr,
  output logic [CNT_W-1:0]     io_fire_count
`ifdef MUTUAL_SCHED_STARVE_EN
  ,
  output logic [NUM_RULES-1:0] io_starve
`endif
);

  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PTR_W-1:0]     sel;
  logic                 found;
  logic [NUM_RULES-1:0] en_a;

  function automatic logic [PTR_W-1:0] rot_idx(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_RULES) s = s - NUM_RULES;
    return PTR_W'(s);
  endfunction

  // Guard and fire belong to the same state, so the enable is purely combinational.
  always_comb begin
    en_a  = '0;
    sel   = '0;
    found = 1'b0;
    if (!reset && !bus.io_stall) begin
      for (int k = 0; k < NUM_RULES; k++) begin
        if (!found && bus.io_guard[rot_idx(ptr_q, k)]) begin
          found = 1'b1;
          sel   = rot_idx(ptr_q, k);
        end
      end
    end
    if (found) en_a[sel] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (found) begin
      ptr_d = rot_idx(sel, 1);
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.io_en_a   = en_a;
  assign bus.io_fired  = found;
  assign io_ptr        = ptr_q;
  assign io_fire_count = cnt_q;

`ifdef MUTUAL_SCHED_STARVE_EN
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

  logic [WAIT_W-1:0]    wait_q [NUM_RULES];
  logic [WAIT_W-1:0]    wait_d [NUM_RULES];
  logic [NUM_RULES-1:0] starve_q, starve_d;

  // Stalled cycles count as waiting: a guarded rule that did not fire is starving.
  always_comb begin
    for (int i = 0; i < NUM_RULES; i++) begin
      wait_d[i] = wait_q[i];
      if (en_a[i] || !bus.io_guard[i]) begin
        wait_d[i] = '0;
      end else if (wait_q[i] != WAIT_W'(STARVE_LIMIT)) begin
        wait_d[i] = wait_q[i] + WAIT_W'(1);
      end
      starve_d[i] = starve_q[i] | (wait_d[i] == WAIT_W'(STARVE_LIMIT));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_RULES; i++) wait_q[i] <= '0;
      starve_q <= '0;
    end else begin
      for (int i = 0; i < NUM_RULES; i++) wait_q[i] <= wait_d[i];
      starve_q <= starve_d;
    end
  end

  assign io_starve = starve_q;
`endif

endmodule

// File: tb/tb_mutual_rule_sched.sv
// tb/tb_mutual_rule_sched.sv - directed table-driven bench for mutual_rule_sched
module tb_mutual_rule_sched;

  logic        clock;
  logic        reset;
  logic [1:0]  ptr,  sat_ptr;
  logic [15:0] cnt;
  logic [1:0]  sat_cnt;
`ifdef MUTUAL_SCHED_STARVE_EN
  logic [2:0]  starve, sat_starve;
`endif

  int total = 0;
  int bad   = 0;

  mutual_rule_sched_if #(.NUM_RULES(3)) mif ();
  mutual_rule_sched_if #(.NUM_RULES(3)) sif ();

  mutual_rule_sched #(.NUM_RULES(3), .STARVE_LIMIT(4), .CNT_W(16)) u_dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (mif),
    .io_ptr        (ptr),
    .io_fire_count (cnt)
`ifdef MUTUAL_SCHED_STARVE_EN
    ,
    .io_starve     (starve)
`endif
  );

  mutual_rule_sched #(.NUM_RULES(3), .STARVE_LIMIT(4), .CNT_W(2)) u_sat (
    .clock         (clock),
    .reset         (reset),
    .bus           (sif),
    .io_ptr        (sat_ptr),
    .io_fire_count (sat_cnt)
`ifdef MUTUAL_SCHED_STARVE_EN
    ,
    .io_starve     (sat_starve)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        stall;
    logic [2:0]  guard;
    logic [2:0]  en;
    logic        fired;
    logic [1:0]  ptr;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 3'b111, 3'b000, 1'b0, 2'd0, 16'd0};
    tbl[1]  = '{1'b0, 1'b0, 3'b111, 3'b001, 1'b1, 2'd0, 16'd0};
    tbl[2]  = '{1'b0, 1'b0, 3'b111, 3'b010, 1'b1, 2'd1, 16'd1};
    tbl[3]  = '{1'b0, 1'b0, 3'b111, 3'b100, 1'b1, 2'd2, 16'd2};
    tbl[4]  = '{1'b0, 1'b0, 3'b111, 3'b001, 1'b1, 2'd0, 16'd3};
    tbl[5]  = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 2'd1, 16'd4};
    tbl[6]  = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 2'd1, 16'd4};
    tbl[7]  = '{1'b0, 1'b0, 3'b010, 3'b010, 1'b1, 2'd1, 16'd4};
    tbl[8]  = '{1'b0, 1'b0, 3'b010, 3'b010, 1'b1, 2'd2, 16'd5};
    tbl[9]  = '{1'b0, 1'b0, 3'b010, 3'b010, 1'b1, 2'd2, 16'd6};
    tbl[10] = '{1'b0, 1'b0, 3'b101, 3'b100, 1'b1, 2'd2, 16'd7};
    tbl[11] = '{1'b0, 1'b0, 3'b101, 3'b001, 1'b1, 2'd0, 16'd8};
    tbl[12] = '{1'b0, 1'b0, 3'b110, 3'b010, 1'b1, 2'd1, 16'd9};
    tbl[13] = '{1'b0, 1'b1, 3'b111, 3'b000, 1'b0, 2'd2, 16'd10};
    tbl[14] = '{1'b0, 1'b0, 3'b011, 3'b001, 1'b1, 2'd2, 16'd10};
    tbl[15] = '{1'b0, 1'b0, 3'b011, 3'b010, 1'b1, 2'd1, 16'd11};
    tbl[16] = '{1'b1, 1'b0, 3'b111, 3'b000, 1'b0, 2'd2, 16'd12};
    tbl[17] = '{1'b0, 1'b0, 3'b111, 3'b001, 1'b1, 2'd0, 16'd0};
    tbl[18] = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 2'd1, 16'd1};

    reset        = 1'b1;
    mif.io_guard = 3'b000;
    mif.io_stall = 1'b0;
    sif.io_guard = 3'b000;
    sif.io_stall = 1'b0;
    repeat (2) @(posedge clock);

    for (int v = 0; v < 19; v++) begin
      @(negedge clock);
      reset        = tbl[v].rst;
      mif.io_stall = tbl[v].stall;
      mif.io_guard = tbl[v].guard;
      #1;
      chk($sformatf("row%0d_en", v),    32'(mif.io_en_a),  32'(tbl[v].en));
      chk($sformatf("row%0d_fired", v), 32'(mif.io_fired), 32'(tbl[v].fired));
      chk($sformatf("row%0d_ptr", v),   32'(ptr),          32'(tbl[v].ptr));
      chk($sformatf("row%0d_cnt", v),   32'(cnt),          32'(tbl[v].cnt));
    end

`ifdef MUTUAL_SCHED_STARVE_EN
    @(negedge clock);
    reset        = 1'b1;
    mif.io_guard = 3'b001;
    mif.io_stall = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("starve_reset", 32'(starve), 32'd0);
    chk("starve_en_stall0", 32'(mif.io_en_a), 32'd0);
    for (int e = 1; e <= 4; e++) begin
      @(negedge clock);
      #1;
      chk($sformatf("starve_edge%0d", e), 32'(starve), (e == 4) ? 32'd1 : 32'd0);
      chk($sformatf("starve_en_stall%0d", e), 32'(mif.io_en_a), 32'd0);
    end
    mif.io_stall = 1'b0;
    #1;
    chk("starve_release_en", 32'(mif.io_en_a), 32'd1);
    @(negedge clock);
    #1;
    chk("starve_sticky", 32'(starve), 32'd1);
    chk("starve_ptr_after_fire", 32'(ptr), 32'd1);
    chk("starve_sat_clear", 32'(sat_starve), 32'd0);
`endif

    @(negedge clock);
    mif.io_guard = 3'b000;
    mif.io_stall = 1'b0;
    sif.io_guard = 3'b100;
    #1;
    chk("sat_start_cnt", 32'(sat_cnt), 32'd0);
    for (int e = 1; e <= 5; e++) begin
      chk($sformatf("sat_en%0d", e), 32'(sif.io_en_a), 32'b100);
      @(negedge clock);
      #1;
      chk($sformatf("sat_cnt%0d", e), 32'(sat_cnt), (e >= 3) ? 32'd3 : 32'(e));
    end
    chk("sat_ptr", 32'(sat_ptr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
